// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scan controller.
package fnd_pkg;

  // Active-low segment fonts, bit order {dp,g,f,e,d,c,b,a}.
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  localparam logic [3:0] COM_OFF = 4'hF;

  // Never returns 0 so a degenerate DIV of 1 still yields a legal vector.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic logic [7:0] digit_font(input logic [3:0] d);
    case (d)
      4'd0:    return FONT_0;
      4'd1:    return FONT_1;
      4'd2:    return FONT_2;
      4'd3:    return FONT_3;
      4'd4:    return FONT_4;
      4'd5:    return FONT_5;
      4'd6:    return FONT_6;
      4'd7:    return FONT_7;
      4'd8:    return FONT_8;
      4'd9:    return FONT_9;
      default: return FONT_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/fnd_bcd_font.sv
// Converts a 0..99 binary value to tens/ones segment fonts; 100 and above show dashes.
module fnd_bcd_font
  import fnd_pkg::*;
(
  input  logic [6:0] value,
  output logic [7:0] tens_font,
  output logic [7:0] ones_font
);

  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens = 4'(value / 7'd10);
    ones = 4'(value % 7'd10);
    if (value >= 7'd100) begin
      tens_font = FONT_DASH;
      ones_font = FONT_DASH;
    end else begin
      tens_font = digit_font(tens);
      ones_font = digit_font(ones);
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame input snapshot.
// Optional macro FND_LEADING_ZERO_BLANK_EN turns off the upper tens digit when it is zero.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] digit_h,
  input  logic [6:0] digit_l,
  input  logic       dot,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_font
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW  = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q;
  logic [1:0]    sel_q;
  logic [6:0]    snap_h_q;
  logic [6:0]    snap_l_q;
  logic          snap_dot_q;

  logic       tick;
  logic       in_gap;
  logic [7:0] h_tens, h_ones, l_tens, l_ones;
  logic [3:0] com_d;
  logic [7:0] font_d;

  assign tick   = (presc_q == LAST);
  assign in_gap = 32'(presc_q) < BLANK_CYC;

  fnd_bcd_font u_font_h (
    .value     (snap_h_q),
    .tens_font (h_tens),
    .ones_font (h_ones)
  );

  fnd_bcd_font u_font_l (
    .value     (snap_l_q),
    .tens_font (l_tens),
    .ones_font (l_ones)
  );

  always_comb begin
    com_d  = COM_OFF;
    font_d = FONT_BLANK;
    if (!in_gap) begin
      unique case (sel_q)
        2'd0: begin
          com_d  = 4'b1110;
          font_d = l_ones;
        end
        2'd1: begin
          com_d  = 4'b1101;
          font_d = l_tens;
        end
        2'd2: begin
          // Fonts always carry dp=1, so masking bit 7 lights the point on request.
          com_d  = 4'b1011;
          font_d = h_ones & {~snap_dot_q, 7'h7F};
        end
        2'd3: begin
`ifdef FND_LEADING_ZERO_BLANK_EN
          if (snap_h_q >= 7'd10) begin
            com_d  = 4'b0111;
            font_d = h_tens;
          end
`else
          com_d  = 4'b0111;
          font_d = h_tens;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q    <= '0;
      sel_q      <= 2'd0;
      snap_h_q   <= 7'd0;
      snap_l_q   <= 7'd0;
      snap_dot_q <= 1'b0;
      fnd_com    <= COM_OFF;
      fnd_font   <= FONT_BLANK;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        sel_q <= sel_q + 2'd1;
      end
      // Frame boundary: sample all inputs together so a frame is coherent.
      if (tick && sel_q == 2'd3) begin
        snap_h_q   <= digit_h;
        snap_l_q   <= digit_l;
        snap_dot_q <= dot;
      end
      fnd_com  <= com_d;
      fnd_font <= font_d;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl with DIV=10, BLANK_CYC=2; honours FND_LEADING_ZERO_BLANK_EN.
module tb_fnd_scan_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] com;
    logic [7:0] font;
    string      name;
  } exp_t;

`ifdef FND_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ_COM  = 4'hF;
  localparam logic [7:0] LZ_FONT = 8'hFF;
`else
  localparam logic [3:0] LZ_COM  = 4'h7;
  localparam logic [7:0] LZ_FONT = 8'hC0;
`endif

  logic       clk;
  logic       reset;
  logic [6:0] digit_h;
  logic [6:0] digit_l;
  logic       dot;
  logic [3:0] fnd_com;
  logic [7:0] fnd_font;

  int   cyc;
  int   total;
  int   bad;
  exp_t q[$];

  fnd_scan_ctrl #(
    .CLK_HZ    (100),
    .SCAN_HZ   (10),
    .BLANK_CYC (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digit_h  (digit_h),
    .digit_l  (digit_l),
    .dot      (dot),
    .fnd_com  (fnd_com),
    .fnd_font (fnd_font)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_one(input int c, input logic [3:0] com, input logic [7:0] font,
                          input string name);
    exp_t e;
    e.cyc  = c;
    e.com  = com;
    e.font = font;
    e.name = name;
    q.push_back(e);
  endtask

  // One digit slot: first n entries starting at cycle start, two blank cycles first.
  task automatic push_slot(input int start, input int n, input logic [3:0] com,
                           input logic [7:0] font, input string name);
    for (int k = 0; k < n; k++) begin
      if (k < 2) push_one(start + k, 4'hF, 8'hFF, {name, "_gap"});
      else       push_one(start + k, com, font, name);
    end
  endtask

  task automatic push_frame(input int r, input int f, input logic [7:0] f0,
                            input logic [7:0] f1, input logic [7:0] f2,
                            input logic [3:0] c3, input logic [7:0] f3);
    int base;
    base = r + 1 + 40 * f;
    push_slot(base,      10, 4'hE, f0, $sformatf("f%0d_sel0", f));
    push_slot(base + 10, 10, 4'hD, f1, $sformatf("f%0d_sel1", f));
    push_slot(base + 20, 10, 4'hB, f2, $sformatf("f%0d_sel2", f));
    push_slot(base + 30, 10, c3,   f3, $sformatf("f%0d_sel3", f));
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every cycle the pins present a value; pop whatever is due and compare.
  initial begin
    exp_t e;
    total = 0;
    bad   = 0;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        total++;
        if (e.cyc != cyc) begin
          bad++;
          $display("FAIL %s cyc=%0d: expectation skipped (now cyc=%0d)", e.name, e.cyc, cyc);
        end else if (fnd_com !== e.com || fnd_font !== e.font) begin
          bad++;
          $display("FAIL %s cyc=%0d: got com=%h font=%h, want com=%h font=%h",
                   e.name, cyc, fnd_com, fnd_font, e.com, e.font);
        end
      end
    end
  end

  initial begin
    int r;
    int r2;
    int waited;
    reset   = 1'b0;
    digit_h = 7'd12;
    digit_l = 7'd34;
    dot     = 1'b1;
    for (int i = 1; i <= 3; i++) push_one(i, 4'hF, 8'hFF, "reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    r = cyc;

    // Frame 0 shows the zeroed reset snapshot; 12/34/dot captured at its end.
    push_frame(r, 0, 8'hC0, 8'hC0, 8'hC0, LZ_COM, LZ_FONT);
    push_frame(r, 1, 8'h99, 8'hB0, 8'h24, 4'h7, 8'hF9);
    wait_cyc(r + 55);
    dot = 1'b0;
    push_frame(r, 2, 8'h99, 8'hB0, 8'hA4, 4'h7, 8'hF9);
    wait_cyc(r + 95);
    digit_l = 7'd56;
    push_frame(r, 3, 8'h82, 8'h92, 8'hA4, 4'h7, 8'hF9);
    wait_cyc(r + 135);
    digit_l = 7'd100;
    digit_h = 7'd127;
    dot     = 1'b1;
    push_frame(r, 4, 8'hBF, 8'hBF, 8'h3F, 4'h7, 8'hBF);
    wait_cyc(r + 175);
    digit_h = 7'd5;
    digit_l = 7'd99;
    dot     = 1'b0;
    push_frame(r, 5, 8'h90, 8'h90, 8'h92, LZ_COM, LZ_FONT);
    wait_cyc(r + 215);
    push_slot(r + 241, 10, 4'hE, 8'h90, "f6_sel0");
    push_slot(r + 251, 10, 4'hD, 8'h90, "f6_sel1");
    push_slot(r + 261, 5,  4'hB, 8'h92, "f6_sel2");

    // Reset in the middle of the lit sel2 slot.
    wait_cyc(r + 265);
    reset = 1'b0;
    push_one(r + 266, 4'hF, 8'hFF, "midreset");
    push_one(r + 267, 4'hF, 8'hFF, "midreset");
    wait_cyc(r + 267);
    reset = 1'b1;
    r2 = cyc;
    push_frame(r2, 0, 8'hC0, 8'hC0, 8'hC0, LZ_COM, LZ_FONT);
    push_frame(r2, 1, 8'h90, 8'h90, 8'h92, LZ_COM, LZ_FONT);
    wait_cyc(r2 + 81);

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
